// File: rtl/mp_arith_pkg.sv
// Shared constants and types for the multi-word add/subtract sequencer.
// Word width, FSM state encoding and operation codes.
package mp_arith_pkg;

   localparam int MP_WORD_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mp_out_stage.sv
// One-entry valid/ready output register; a load lands one cycle later on out_dat_o.
// Backpressure: space_o drops while full and the consumer is not taking the word.
module mp_out_stage #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_dat_i,
   input  logic         out_ready_i,
   output logic         out_valid_o,
   output logic [W-1:0] out_dat_o,
   output logic         space_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] dat_q, dat_d;

   always_comb begin
      valid_d = valid_q;
      dat_d   = dat_q;
      // A load wins over a drain so a same-cycle accept and load keeps the stage full.
      if (load_i) begin
         valid_d = 1'b1;
         dat_d   = load_dat_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         dat_q   <= '0;
      end else begin
         valid_q <= valid_d;
         dat_q   <= dat_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_dat_o   = dat_q;
   assign space_o     = !valid_q || out_ready_i;

endmodule

// File: rtl/mp_add_sequencer.sv
// Streams NUM_WORDS word pairs LS-first through an external adder, threading carry; one-cycle word latency.
// Backpressure: in_ready follows the output register, so a stalled out_ready stalls input and carry.
module mp_add_sequencer
   import mp_arith_pkg::*;
#(
   parameter int WORD_W    = MP_WORD_W,
   parameter int NUM_WORDS = 16,
   parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op_sub,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a_word,
   input  logic [WORD_W-1:0] b_word,
   output logic [WORD_W-1:0] add_a,
   output logic [WORD_W-1:0] add_b,
   output logic              add_cin,
   input  logic [WORD_W-1:0] add_sum,
   input  logic              add_cout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] sum_word,
   output logic              carry_out,
   output logic              done
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   state_t           state_q, state_d;
   logic             sub_q, sub_d;
   logic             carry_q, carry_d;
   logic             carry_out_q, carry_out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stage_space;
   logic             accept;

   // Subtraction is A + ~B + 1, the +1 entering through the initial carry.
   assign add_a   = a_word;
   assign add_b   = b_word ^ {WORD_W{sub_q == OP_SUB}};
   assign add_cin = carry_q;

   assign in_ready = (state_q == RUN) && stage_space;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      sub_d       = sub_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sub_d   = op_sub;
               carry_d = op_sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               carry_d = add_cout;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (out_valid && out_ready) begin
               carry_out_d = carry_q;
               state_d     = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         sub_q       <= sub_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         cnt_q       <= cnt_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign carry_out = carry_out_q;

   mp_out_stage #(
      .W (WORD_W)
   ) u_out_stage (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept),
      .load_dat_i  (add_sum),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_dat_o   (sum_word),
      .space_o     (stage_space)
   );

endmodule
